// File: rtl/vram_wr_sched_if.sv
// Request bus from the HPS bridge plus the single VRAM write port toward the PPU.
interface vram_wr_sched_if;
  logic        req_valid;
  logic        req_ready;
  logic [12:0] req_addr;
  logic [63:0] req_data;
  logic [7:0]  req_byteena;
  logic        req_last;

  logic [12:0] h2f_vram_wraddr;
  logic        h2f_vram_wren;
  logic [63:0] h2f_vram_wrdata;
  logic [7:0]  h2f_vram_byteena;

  modport master (
    output req_valid, req_addr, req_data, req_byteena, req_last,
    input  req_ready,
    input  h2f_vram_wraddr, h2f_vram_wren, h2f_vram_wrdata, h2f_vram_byteena
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_byteena, req_last,
    output req_ready,
    output h2f_vram_wraddr, h2f_vram_wren, h2f_vram_wrdata, h2f_vram_byteena
  );
endinterface

// File: rtl/vram_wr_sched.sv
// Buffers CPU VRAM writes and drains them one per cycle only inside the IRQ-opened window.
// Optional address range filtering: define VRAM_WR_SCHED_RANGE_CHECK_EN.
module vram_wr_sched #(
  parameter int          FIFO_DEPTH     = 16,
  parameter int          WINDOW_CYCLES  = 4096,
  parameter logic [12:0] VRAM_LAST_ADDR = 13'h1A27
) (
  input  logic                          clk,
  input  logic                          rst_n,
  vram_wr_sched_if.slave                bus,
  input  logic                          cpu_vram_wr_irq,
  output logic                          cpu_wr_busy,
  output logic                          batch_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_count
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] WIN_C   = 16'(WINDOW_CYCLES);

  typedef struct packed {
    logic [12:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic        last;
  } entry_t;

  typedef enum logic {CLOSED, OPEN} state_t;

  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   budget, budget_nxt;
  state_t        state, state_nxt;
  logic          accept, in_range, push, pop;

  assign bus.req_ready = (count != DEPTH_C);
  assign accept        = bus.req_valid && bus.req_ready;
  assign push          = accept && in_range;
  assign pop           = (state == OPEN) && (count != '0);
  assign head          = mem[rd_ptr];
  assign fifo_count    = count;
  assign cpu_wr_busy   = (state == OPEN) && ((count != '0) || bus.h2f_vram_wren);

`ifdef VRAM_WR_SCHED_RANGE_CHECK_EN
  assign in_range = (bus.req_addr <= VRAM_LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                      drop_count <= '0;
    else if (accept && !in_range && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
`else
  // Without the check the limit has no effect; every accepted request is stored.
  assign in_range   = 1'b1 | (bus.req_addr <= VRAM_LAST_ADDR);
  assign drop_count = '0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= CLOSED;
      budget <= '0;
    end else begin
      state  <= state_nxt;
      budget <= budget_nxt;
    end

  // A re-fire while open only refreshes the budget; the last pop lands on the 1->0 edge.
  always_comb begin
    state_nxt  = state;
    budget_nxt = budget;
    unique case (state)
      CLOSED: if (cpu_vram_wr_irq) begin
        state_nxt  = OPEN;
        budget_nxt = WIN_C;
      end
      OPEN: if (cpu_vram_wr_irq) begin
        budget_nxt = WIN_C;
      end else begin
        budget_nxt = budget - 16'd1;
        if (budget <= 16'd1) state_nxt = CLOSED;
      end
    endcase
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= '{bus.req_addr, bus.req_data, bus.req_byteena, bus.req_last};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      count                <= '0;
      bus.h2f_vram_wren    <= 1'b0;
      bus.h2f_vram_wraddr  <= '0;
      bus.h2f_vram_wrdata  <= '0;
      bus.h2f_vram_byteena <= '0;
      batch_done           <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      bus.h2f_vram_wren <= pop;
      batch_done        <= pop && head.last;
      if (pop) begin
        bus.h2f_vram_wraddr  <= head.addr;
        bus.h2f_vram_wrdata  <= head.data;
        bus.h2f_vram_byteena <= head.be;
      end
    end
endmodule

// File: tb/tb_vram_wr_sched.sv
// Directed bench for vram_wr_sched: table-driven drain plus window, full, extension, range and reset sequences.
module tb_vram_wr_sched;
  localparam int W = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       irq = 1'b0;
  logic       busy, bd;
  logic [4:0] fcnt;
  logic [7:0] dcnt;

  vram_wr_sched_if bus();

  vram_wr_sched #(.FIFO_DEPTH(16), .WINDOW_CYCLES(W), .VRAM_LAST_ADDR(13'h1A27)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .cpu_vram_wr_irq(irq),
    .cpu_wr_busy(busy), .batch_done(bd), .fifo_count(fcnt), .drop_count(dcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic        last;
    logic        exp_bd;
  } vec_t;

  vec_t tbl [8];
  vec_t exp_q [$];
  int   nchk = 0;
  int   nbad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push(input logic [12:0] a, input logic [63:0] d, input logic [7:0] be, input logic last);
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_data = d; bus.req_byteena = be; bus.req_last = last;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic qpush(input logic [12:0] a, input logic [63:0] d, input logic [7:0] be, input logic last);
    push(a, d, be, last);
    exp_q.push_back('{a, d, be, last, last});
  endtask

  task automatic pulse_irq();
    irq = 1'b1; step(); irq = 1'b0;
  endtask

  // Compare the current write-port cycle against the head of the expected-write queue.
  task automatic chk_write(input string nm);
    vec_t e;
    if (exp_q.size() == 0) begin
      nchk++; nbad++;
      $display("FAIL %s: write seen with nothing expected", nm);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, " wren"}, bus.h2f_vram_wren, 1'b1);
    chk({nm, " addr"}, bus.h2f_vram_wraddr, e.addr);
    chk({nm, " data"}, bus.h2f_vram_wrdata, e.data);
    chk({nm, " be"}, bus.h2f_vram_byteena, e.be);
    chk({nm, " batch_done"}, bd, e.exp_bd);
  endtask

  function automatic logic [63:0] mk(input int i);
    return {32'hCAFE0000 + 32'(i), 32'(i) * 32'h9E3779B9};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_data = '0; bus.req_byteena = '0; bus.req_last = 1'b0;

    tbl[0] = '{13'h0000, 64'h0000_0000_0000_0001, 8'hFF, 1'b0, 1'b0};
    tbl[1] = '{13'h07FF, 64'h1111_2222_3333_4444, 8'h0F, 1'b0, 1'b0};
    tbl[2] = '{13'h0800, 64'hDEAD_BEEF_0000_0002, 8'hF0, 1'b0, 1'b0};
    tbl[3] = '{13'h17FF, 64'h0123_4567_89AB_CDEF, 8'h01, 1'b0, 1'b0};
    tbl[4] = '{13'h1800, 64'hFFFF_FFFF_FFFF_FFFF, 8'h80, 1'b0, 1'b0};
    tbl[5] = '{13'h19FF, 64'h5A5A_A5A5_5A5A_A5A5, 8'h3C, 1'b0, 1'b0};
    tbl[6] = '{13'h1A00, 64'h8000_0000_0000_0000, 8'hC3, 1'b0, 1'b0};
    tbl[7] = '{13'h1A27, 64'h0BAD_F00D_0BAD_F00D, 8'hAA, 1'b1, 1'b1};

    // Reset state
    #3;
    chk("rst wren", bus.h2f_vram_wren, 1'b0);
    chk("rst addr", bus.h2f_vram_wraddr, 13'h0);
    chk("rst data", bus.h2f_vram_wrdata, 64'h0);
    chk("rst be", bus.h2f_vram_byteena, 8'h0);
    chk("rst ready", bus.req_ready, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst batch_done", bd, 1'b0);
    chk("rst fifo_count", fcnt, 5'd0);
    chk("rst drop_count", dcnt, 8'd0);
    #20 rst_n = 1'b1;
    step();

    // Table-driven: queue 8, nothing written until the IRQ, then drained in order
    for (int i = 0; i < 8; i++) begin
      push(tbl[i].addr, tbl[i].data, tbl[i].be, tbl[i].last);
      chk("closed no wren", bus.h2f_vram_wren, 1'b0);
    end
    chk("tbl fifo_count", fcnt, 5'd8);
    pulse_irq();
    chk("irq edge no wren", bus.h2f_vram_wren, 1'b0);
    chk("irq edge busy", busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("tbl wren", bus.h2f_vram_wren, 1'b1);
      chk("tbl addr", bus.h2f_vram_wraddr, tbl[i].addr);
      chk("tbl data", bus.h2f_vram_wrdata, tbl[i].data);
      chk("tbl be", bus.h2f_vram_byteena, tbl[i].be);
      chk("tbl batch_done", bd, tbl[i].exp_bd);
      chk("tbl busy", busy, 1'b1);
    end
    step();
    chk("tbl end wren", bus.h2f_vram_wren, 1'b0);
    chk("tbl end busy", busy, 1'b0);
    chk("tbl end batch_done", bd, 1'b0);
    chk("tbl hold addr", bus.h2f_vram_wraddr, 13'h1A27);
    idle(W + 2);

    // Window budget: 12 queued, only W written per IRQ, remainder kept
    for (int i = 0; i < 12; i++) qpush(13'h100 + 13'(i), mk(i), 8'h01 << (i % 8), i == 11);
    pulse_irq();
    for (int k = 0; k < W; k++) begin step(); chk_write("win1"); end
    step();
    chk("win1 closed wren", bus.h2f_vram_wren, 1'b0);
    chk("win1 left", fcnt, 5'd2);
    idle(3);
    chk("win1 held", fcnt, 5'd2);
    chk("win1 held wren", bus.h2f_vram_wren, 1'b0);
    pulse_irq();
    for (int k = 0; k < 2; k++) begin step(); chk_write("win2"); end
    step();
    chk("win2 wren", bus.h2f_vram_wren, 1'b0);
    chk("win2 empty", fcnt, 5'd0);
    idle(W + 2);

    // Full FIFO: back-pressure until the first pop
    for (int i = 0; i < 16; i++) qpush(13'h200 + 13'(i), mk(100 + i), 8'hFF, 1'b0);
    chk("full ready", bus.req_ready, 1'b0);
    chk("full count", fcnt, 5'd16);
    push(13'h3FF, 64'h1, 8'h1, 1'b0);
    chk("full no accept", fcnt, 5'd16);
    pulse_irq();
    chk("full ready at irq", bus.req_ready, 1'b0);
    step();
    chk_write("full");
    chk("full ready after pop", bus.req_ready, 1'b1);
    chk("full count after pop", fcnt, 5'd15);
    for (int k = 1; k < W; k++) begin step(); chk_write("full"); end
    step();
    chk("full left", fcnt, 5'd6);
    idle(W);
    pulse_irq();
    for (int k = 0; k < 6; k++) begin step(); chk_write("full2"); end
    idle(W + 2);

    // Window extension: IRQ re-fired with budget at 2, 14 writes with no gap
    for (int i = 0; i < 14; i++) qpush(13'h300 + 13'(i), mk(200 + i), 8'h55, i == 13);
    pulse_irq();
    for (int k = 1; k <= 14; k++) begin
      irq = (k == 9);
      step();
      irq = 1'b0;
      chk_write("ext");
    end
    step();
    chk("ext end wren", bus.h2f_vram_wren, 1'b0);
    chk("ext empty", fcnt, 5'd0);
    idle(W + 2);

`ifdef VRAM_WR_SCHED_RANGE_CHECK_EN
    push(13'h1A28, 64'h1, 8'hFF, 1'b0);
    push(13'h1FFF, 64'h2, 8'hFF, 1'b1);
    chk("range not stored", fcnt, 5'd0);
    chk("range drop 2", dcnt, 8'd2);
    pulse_irq();
    for (int k = 0; k <= W; k++) begin step(); chk("range no wren", bus.h2f_vram_wren, 1'b0); end
    for (int i = 0; i < 300; i++) push(13'h1A28 + 13'(i % 64), 64'(i), 8'h1, 1'b0);
    chk("range saturate", dcnt, 8'd255);
    chk("range still empty", fcnt, 5'd0);
`else
    qpush(13'h1A28, 64'h77, 8'h0F, 1'b1);
    chk("norange stored", fcnt, 5'd1);
    chk("norange drop 0", dcnt, 8'd0);
    pulse_irq();
    step();
    chk_write("norange");
    idle(W + 2);
`endif

    // Reset during the 3rd write of a 6-write drain
    for (int i = 0; i < 6; i++) qpush(13'h400 + 13'(i), mk(300 + i), 8'hF0, i == 5);
    pulse_irq();
    for (int k = 0; k < 3; k++) begin step(); chk_write("prerst"); end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst wren", bus.h2f_vram_wren, 1'b0);
    chk("midrst count", fcnt, 5'd0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst ready", bus.req_ready, 1'b1);
    chk("midrst addr", bus.h2f_vram_wraddr, 13'h0);
    exp_q.delete();
    #10 rst_n = 1'b1;
    step();
    pulse_irq();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("postrst no wren", bus.h2f_vram_wren, 1'b0);
    end
    chk("postrst count", fcnt, 5'd0);

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
